wb_multi: RTL and testbench
===========================

Name: wb_multi

Overview:
- Parametrised successor to the single-lane writeback stage.
- Retires up to NUM_LANES results per cycle into the register file; lane 0 is the oldest.
- Selects load data or ALU result per lane and suppresses writes to x0.
- Handles ECALL with a multi-cycle request/acknowledge FSM to an external handler, not an in-stage call. On completion it writes the result to a0, stalls upstream while waiting, then flushes and redirects the PC.

Parameters:
NUM_LANES, 2, number of parallel writeback lanes (1-4)
XLEN, 64, register data width
REGBITS, 5, register index width
PCW, 32, program counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  NUM_LANES  lane carries a retiring instruction
in_pc  in  NUM_LANES x PCW  lane instruction PC
in_ld_or_alu  in  NUM_LANES  1 = take in_lddata, 0 = take in_alures
in_lddata  in  NUM_LANES x XLEN  load result
in_alures  in  NUM_LANES x XLEN  ALU result
in_rd  in  NUM_LANES x REGBITS  destination register
in_is_ecall  in  NUM_LANES  lane is an ECALL
wb_flush  in  1  squash all lanes presented this cycle
ecall_reg_val  in  8 x XLEN  current a0..a7 values
ecall_req  out  1  request to ECALL handler
ecall_args  out  8 x XLEN  latched a0..a7 (a7 = call number)
ecall_ack  in  1  handler done; ecall_result valid
ecall_result  in  XLEN  value for a0
rf_we  out  NUM_LANES  register write enable per lane
rf_addr  out  NUM_LANES x REGBITS  write address
rf_data  out  NUM_LANES x XLEN  write data
wb_stall  out  1  upstream must hold inputs
ecall_flush  out  1  one-cycle flush pulse
pc_after_flush  out  PCW  redirect target

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM = IDLE, latched args/PC cleared. Reset mid-ECALL abandons the call; ecall_req drops immediately.
- All outputs are registered; latency is 1 cycle from input to rf_*.
- IDLE, no ECALL: for each lane i, rf_we[i] = in_valid[i] & (in_rd[i] != 0) & ~wb_flush; rf_data[i] = mux(in_ld_or_alu[i]); rf_addr[i] = in_rd[i].
- IDLE, wb_flush=1: all rf_we = 0 next cycle; ECALL lanes also ignored.
- Same-rd conflict: if lanes i<j are both enabled with equal rd, rf_we[i] is cleared (younger wins).
- ECALL detect in IDLE: k = lowest lane with in_valid & in_is_ecall and wb_flush=0.
  - Lanes < k retire normally; lanes > k are discarded.
  - Lane k writes nothing yet.
  - Latch ecall_reg_val into ecall_args and latch in_pc[k]+4.
  - Next state REQ.
- REQ: ecall_req=1, wb_stall=1, rf_we=0. Stay until ecall_ack=1, then latch ecall_result and go to DONE.
  - ecall_ack outside REQ is ignored.
  - wb_flush in REQ/DONE is ignored.
- DONE (one cycle):
  - Registered effect: rf_we[0]=1, rf_addr[0]=10, rf_data[0]=result, other lanes 0; ecall_flush=1; pc_after_flush = latched PC+4.
  - wb_stall=1 while in DONE; return to IDLE.
- ecall_flush is high for exactly one cycle per ECALL; otherwise 0.
- pc_after_flush holds its last value when ecall_flush=0.
- PC+4 wraps modulo 2^PCW.

Optional Feature:
WB_INSTRET_EN
- Defined: adds output instret (64 bits, reset 0).
  - Increments each cycle by the number of lanes retired that cycle, where a lane retires if valid, not squashed by wb_flush, not discarded after an ECALL, and rd==x0 still counts.
  - A completed ECALL adds 1 in its DONE cycle.
  - The counter wraps at 2^64.
- Undefined: no port, no counter logic.

Test Plan:
- NUM_LANES=2; lane0 alu, rd=3, alures=0x11; lane1 load, rd=4, lddata=0x22 -> next cycle rf_we=11, addrs 3/4, data 0x11/0x22.
- Both lanes rd=5, data 0xA/0xB -> rf_we=10, rf_addr[1]=5, rf_data[1]=0xB.
- Lane0 rd=0 valid; wb_flush=1 with lane1 valid -> rf_we=00 in both cases.
- ECALL on lane1 at pc=0x100, lane0 rd=6; a7=64, a0=1; ack after 3 REQ cycles with result=0x5 ->
  - lane0 writes x6 first;
  - ecall_req high 3 cycles with ecall_args[7]=64;
  - then rf_addr[0]=10, rf_data[0]=0x5;
  - ecall_flush pulses once; pc_after_flush=0x104;
  - wb_stall high throughout.
- ECALL on lane0 with lane1 valid rd=7 -> x7 never written; wb_flush asserted during REQ changes nothing.
- Reset asserted during REQ -> ecall_req, wb_stall, rf_we drop asynchronously; after release, normal retire works.

Source files
------------

// File: rtl/wb_multi_if.sv
// Bundle of the wb_multi lane inputs, ECALL handler handshake and register-file write ports.
// The slave modport is the writeback stage; the master modport is its environment.
interface wb_multi_if #(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = 64,
    parameter int REGBITS   = 5,
    parameter int PCW       = 32
);
    logic [NUM_LANES-1:0]              in_valid;
    logic [NUM_LANES-1:0][PCW-1:0]     in_pc;
    logic [NUM_LANES-1:0]              in_ld_or_alu;
    logic [NUM_LANES-1:0][XLEN-1:0]    in_lddata;
    logic [NUM_LANES-1:0][XLEN-1:0]    in_alures;
    logic [NUM_LANES-1:0][REGBITS-1:0] in_rd;
    logic [NUM_LANES-1:0]              in_is_ecall;
    logic                              wb_flush;
    logic [7:0][XLEN-1:0]              ecall_reg_val;
    logic                              ecall_req;
    logic [7:0][XLEN-1:0]              ecall_args;
    logic                              ecall_ack;
    logic [XLEN-1:0]                   ecall_result;
    logic [NUM_LANES-1:0]              rf_we;
    logic [NUM_LANES-1:0][REGBITS-1:0] rf_addr;
    logic [NUM_LANES-1:0][XLEN-1:0]    rf_data;
    logic                              wb_stall;
    logic                              ecall_flush;
    logic [PCW-1:0]                    pc_after_flush;

    modport slave (
        input  in_valid, in_pc, in_ld_or_alu, in_lddata, in_alures, in_rd, in_is_ecall,
        input  wb_flush, ecall_reg_val, ecall_ack, ecall_result,
        output ecall_req, ecall_args, rf_we, rf_addr, rf_data, wb_stall, ecall_flush,
        output pc_after_flush
    );

    modport master (
        output in_valid, in_pc, in_ld_or_alu, in_lddata, in_alures, in_rd, in_is_ecall,
        output wb_flush, ecall_reg_val, ecall_ack, ecall_result,
        input  ecall_req, ecall_args, rf_we, rf_addr, rf_data, wb_stall, ecall_flush,
        input  pc_after_flush
    );
endinterface

// File: rtl/wb_multi.sv
// Multi-lane writeback stage: retires up to NUM_LANES results per cycle and hands ECALLs to an
// external handler. Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module wb_multi #(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = 64,
    parameter int REGBITS   = 5,
    parameter int PCW       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_multi_if.slave   bus
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0] instret_o
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    localparam logic [REGBITS-1:0] A0_REG = REGBITS'(10);

    state_e                            state_q;
    logic [NUM_LANES-1:0]              rf_we_q;
    logic [NUM_LANES-1:0][REGBITS-1:0] rf_addr_q;
    logic [NUM_LANES-1:0][XLEN-1:0]    rf_data_q;
    logic [7:0][XLEN-1:0]              args_q;
    logic [PCW-1:0]                    ret_pc_q;
    logic [PCW-1:0]                    pc_after_flush_q;
    logic                              ecall_req_q;
    logic                              wb_stall_q;
    logic                              ecall_flush_q;

    logic [NUM_LANES-1:0]              keep_d;
    logic [NUM_LANES-1:0]              wr_d;
    logic [NUM_LANES-1:0]              rf_we_d;
    logic [NUM_LANES-1:0][XLEN-1:0]    rf_data_d;
    logic                              ecall_hit_d;
    logic [PCW-1:0]                    ecall_pc_d;
    logic                              seen_d;
    logic                              live_d;
    logic                              is_k_d;

    // Lanes older than the first live ECALL retire; the ECALL lane and everything younger do not.
    always_comb begin
        keep_d      = '0;
        wr_d        = '0;
        rf_we_d     = '0;
        rf_data_d   = '0;
        ecall_hit_d = 1'b0;
        ecall_pc_d  = '0;
        seen_d      = 1'b0;
        live_d      = 1'b0;
        is_k_d      = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            live_d       = bus.in_valid[i] & ~bus.wb_flush;
            is_k_d       = live_d & bus.in_is_ecall[i] & ~seen_d;
            keep_d[i]    = live_d & ~seen_d & ~bus.in_is_ecall[i];
            wr_d[i]      = keep_d[i] & (bus.in_rd[i] != '0);
            rf_data_d[i] = bus.in_ld_or_alu[i] ? bus.in_lddata[i] : bus.in_alures[i];
            if (is_k_d) begin
                ecall_hit_d = 1'b1;
                ecall_pc_d  = bus.in_pc[i];
            end
            seen_d = seen_d | is_k_d;
        end
        // A younger lane writing the same register makes the older write dead.
        for (int i = 0; i < NUM_LANES; i++) begin
            rf_we_d[i] = wr_d[i];
            for (int j = i + 1; j < NUM_LANES; j++) begin
                if (wr_d[j] && (bus.in_rd[j] == bus.in_rd[i])) begin
                    rf_we_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            rf_we_q          <= '0;
            rf_addr_q        <= '0;
            rf_data_q        <= '0;
            args_q           <= '0;
            ret_pc_q         <= '0;
            pc_after_flush_q <= '0;
            ecall_req_q      <= 1'b0;
            wb_stall_q       <= 1'b0;
            ecall_flush_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rf_we_q       <= rf_we_d;
                    rf_addr_q     <= bus.in_rd;
                    rf_data_q     <= rf_data_d;
                    ecall_flush_q <= 1'b0;
                    ecall_req_q   <= ecall_hit_d;
                    wb_stall_q    <= ecall_hit_d;
                    if (ecall_hit_d) begin
                        state_q  <= REQ;
                        args_q   <= bus.ecall_reg_val;
                        ret_pc_q <= ecall_pc_d + PCW'(4);
                    end
                end
                REQ: begin
                    rf_we_q       <= '0;
                    ecall_flush_q <= 1'b0;
                    wb_stall_q    <= 1'b1;
                    if (bus.ecall_ack) begin
                        state_q          <= DONE;
                        ecall_req_q      <= 1'b0;
                        rf_we_q          <= NUM_LANES'(1);
                        rf_addr_q        <= '0;
                        rf_addr_q[0]     <= A0_REG;
                        rf_data_q        <= '0;
                        rf_data_q[0]     <= bus.ecall_result;
                        ecall_flush_q    <= 1'b1;
                        pc_after_flush_q <= ret_pc_q;
                    end
                end
                DONE: begin
                    state_q       <= IDLE;
                    rf_we_q       <= '0;
                    ecall_flush_q <= 1'b0;
                    ecall_req_q   <= 1'b0;
                    wb_stall_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rf_we          = rf_we_q;
    assign bus.rf_addr        = rf_addr_q;
    assign bus.rf_data        = rf_data_q;
    assign bus.ecall_args     = args_q;
    assign bus.ecall_req      = ecall_req_q;
    assign bus.wb_stall       = wb_stall_q;
    assign bus.ecall_flush    = ecall_flush_q;
    assign bus.pc_after_flush = pc_after_flush_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;
    logic [63:0] retire_cnt_d;

    // x0 destinations still count as retired; the ECALL itself counts when it completes.
    always_comb begin
        retire_cnt_d = '0;
        if (state_q == IDLE) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                retire_cnt_d = retire_cnt_d + 64'(keep_d[i]);
            end
        end else if ((state_q == REQ) && bus.ecall_ack) begin
            retire_cnt_d = 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_q + retire_cnt_d;
        end
    end

    assign instret_o = instret_q;
`endif
endmodule

// File: tb/tb_wb_multi.sv
// Self-checking bench for wb_multi: directed vector table, ECALL sequences, async reset, random retire.
module tb_wb_multi;
    localparam int NL = 2;
    localparam int XL = 64;
    localparam int RB = 5;
    localparam int PW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_multi_if #(.NUM_LANES(NL), .XLEN(XL), .REGBITS(RB), .PCW(PW)) bus ();
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    wb_multi #(.NUM_LANES(NL), .XLEN(XL), .REGBITS(RB), .PCW(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef WB_INSTRET_EN
        ,
        .instret_o (instret)
`endif
    );

    typedef struct {
        logic [NL-1:0] valid;
        logic [NL-1:0] ld;
        logic          flush;
        logic [RB-1:0] rd0;
        logic [RB-1:0] rd1;
        logic [XL-1:0] d0;
        logic [XL-1:0] d1;
        logic [NL-1:0] we;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [XL-1:0] model_rf [32];
    logic [XL-1:0] dut_rf   [32];
    int writes_to_x7 = 0;
    int flush_pulses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) begin
            if (bus.rf_we[i] === 1'b1) begin
                dut_rf[bus.rf_addr[i]] = bus.rf_data[i];
                if (bus.rf_addr[i] == 5'd7) writes_to_x7++;
            end
        end
        if (bus.ecall_flush === 1'b1) flush_pulses++;
    endtask

    task automatic idle_inputs();
        bus.in_valid     = '0;
        bus.in_pc        = '0;
        bus.in_ld_or_alu = '0;
        bus.in_lddata    = '0;
        bus.in_alures    = '0;
        bus.in_rd        = '0;
        bus.in_is_ecall  = '0;
        bus.wb_flush     = 1'b0;
        bus.ecall_ack    = 1'b0;
        bus.ecall_result = '0;
    endtask

    // Put value d on lane i through the selected source and a decoy on the other source.
    task automatic drive_lane(input int i, input logic v, input logic ld, input logic [RB-1:0] rd,
                              input logic [XL-1:0] d);
        bus.in_valid[i]     = v;
        bus.in_ld_or_alu[i] = ld;
        bus.in_rd[i]        = rd;
        bus.in_lddata[i]    = ld ? d : ~d;
        bus.in_alures[i]    = ld ? ~d : d;
    endtask

    // Reference: instructions retire in program order up to the first live ECALL;
    // a lane's write is visible only if it is the last writer of its register.
    task automatic model_cycle(output logic [NL-1:0] exp_we, output logic ecall_seen);
        int stop;
        int last [32];
        exp_we     = '0;
        ecall_seen = 1'b0;
        stop       = bus.wb_flush ? 0 : NL;
        for (int r = 0; r < 32; r++) last[r] = -1;
        if (!bus.wb_flush) begin
            for (int i = 0; i < NL; i++) begin
                if (bus.in_valid[i] && bus.in_is_ecall[i]) begin
                    stop       = i;
                    ecall_seen = 1'b1;
                    break;
                end
            end
        end
        for (int i = 0; i < stop; i++) begin
            if (bus.in_valid[i] && bus.in_rd[i] != 0) begin
                model_rf[bus.in_rd[i]] = bus.in_ld_or_alu[i] ? bus.in_lddata[i] : bus.in_alures[i];
                last[bus.in_rd[i]] = i;
            end
        end
        for (int r = 1; r < 32; r++) begin
            if (last[r] >= 0) exp_we[last[r]] = 1'b1;
        end
    endtask

    task automatic wait_done(output logic got, inout int req_cycles);
        got = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step();
            bus.ecall_ack = 1'b0;
            if (bus.ecall_req === 1'b1) req_cycles++;
            if (bus.ecall_flush === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("ecall_done_seen", 64'(got), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t          vecs [9];
        logic [NL-1:0] exp_we;
        logic          eseen;
        logic          got;
        int            req_cycles;
        logic [XL-1:0] d [NL];

        vecs[0] = '{2'b11, 2'b10, 1'b0, 5'd3, 5'd4,  64'h11, 64'h22, 2'b11};
        vecs[1] = '{2'b11, 2'b00, 1'b0, 5'd5, 5'd5,  64'hA,  64'hB,  2'b10};
        vecs[2] = '{2'b01, 2'b00, 1'b0, 5'd0, 5'd9,  64'h33, 64'h44, 2'b00};
        vecs[3] = '{2'b10, 2'b00, 1'b1, 5'd1, 5'd9,  64'h55, 64'h66, 2'b00};
        vecs[4] = '{2'b11, 2'b11, 1'b1, 5'd2, 5'd3,  64'h77, 64'h88, 2'b00};
        vecs[5] = '{2'b10, 2'b10, 1'b0, 5'd0, 5'd31, 64'h1,  64'hDEAD, 2'b10};
        vecs[6] = '{2'b11, 2'b01, 1'b0, 5'd1, 5'd0,  64'hFEED_0000_0000_0001, 64'h2, 2'b01};
        vecs[7] = '{2'b11, 2'b11, 1'b0, 5'd0, 5'd0,  64'h3,  64'h4,  2'b00};
        vecs[8] = '{2'b11, 2'b11, 1'b0, 5'd8, 5'd8,  64'h8A, 64'h8B, 2'b10};

        for (int r = 0; r < 32; r++) begin
            model_rf[r] = '0;
            dut_rf[r]   = '0;
        end
        idle_inputs();
        bus.ecall_reg_val = '0;
        rst_n = 1'b0;
        #2;
        check("reset_rf_we", 64'(bus.rf_we), 64'd0);
        check("reset_req", 64'(bus.ecall_req), 64'd0);
        check("reset_stall", 64'(bus.wb_stall), 64'd0);
        check("reset_eflush", 64'(bus.ecall_flush), 64'd0);
        check("reset_pc", 64'(bus.pc_after_flush), 64'd0);
        check("reset_args7", bus.ecall_args[7], 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed lane vectors
        for (int v = 0; v < 9; v++) begin
            idle_inputs();
            drive_lane(0, vecs[v].valid[0], vecs[v].ld[0], vecs[v].rd0, vecs[v].d0);
            drive_lane(1, vecs[v].valid[1], vecs[v].ld[1], vecs[v].rd1, vecs[v].d1);
            bus.wb_flush = vecs[v].flush;
            model_cycle(exp_we, eseen);
            step();
            check($sformatf("vec%0d_we", v), 64'(bus.rf_we), 64'(vecs[v].we));
            if (vecs[v].we[0]) begin
                check($sformatf("vec%0d_addr0", v), 64'(bus.rf_addr[0]), 64'(vecs[v].rd0));
                check($sformatf("vec%0d_data0", v), bus.rf_data[0], vecs[v].d0);
            end
            if (vecs[v].we[1]) begin
                check($sformatf("vec%0d_addr1", v), 64'(bus.rf_addr[1]), 64'(vecs[v].rd1));
                check($sformatf("vec%0d_data1", v), bus.rf_data[1], vecs[v].d1);
            end
        end

        // ECALL on lane 1, lane 0 retires first; handler answers after three request cycles
        idle_inputs();
        bus.ecall_ack    = 1'b1;
        bus.ecall_result = 64'h99;
        step();
        check("ack_idle_eflush", 64'(bus.ecall_flush), 64'd0);
        check("ack_idle_req", 64'(bus.ecall_req), 64'd0);
        idle_inputs();
        for (int k = 0; k < 8; k++) bus.ecall_reg_val[k] = 64'h1000 + 64'(k);
        bus.ecall_reg_val[0] = 64'd1;
        bus.ecall_reg_val[7] = 64'd64;
        drive_lane(0, 1'b1, 1'b0, 5'd6, 64'h66);
        drive_lane(1, 1'b1, 1'b0, 5'd11, 64'hBAD);
        bus.in_is_ecall = 2'b10;
        bus.in_pc[0]    = 32'hFC;
        bus.in_pc[1]    = 32'h100;
        model_cycle(exp_we, eseen);
        flush_pulses = 0;
        step();
        check("ec1_we", 64'(bus.rf_we), 64'(exp_we));
        check("ec1_addr0", 64'(bus.rf_addr[0]), 64'd6);
        check("ec1_data0", bus.rf_data[0], 64'h66);
        check("ec1_req", 64'(bus.ecall_req), 64'd1);
        check("ec1_stall", 64'(bus.wb_stall), 64'd1);
        check("ec1_args0", bus.ecall_args[0], 64'd1);
        check("ec1_args3", bus.ecall_args[3], 64'h1003);
        check("ec1_args7", bus.ecall_args[7], 64'd64);
        idle_inputs();
        bus.ecall_reg_val = '0;
        req_cycles = (bus.ecall_req === 1'b1) ? 1 : 0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (bus.ecall_req === 1'b1) req_cycles++;
            check("ec1_req_stall", 64'(bus.wb_stall), 64'd1);
            check("ec1_req_we", 64'(bus.rf_we), 64'd0);
        end
        bus.ecall_ack    = 1'b1;
        bus.ecall_result = 64'h5;
        wait_done(got, req_cycles);
        model_rf[10] = 64'h5;
        check("ec1_req_cycles", 64'(req_cycles), 64'd3);
        check("ec1_done_we", 64'(bus.rf_we), 64'b01);
        check("ec1_done_addr0", 64'(bus.rf_addr[0]), 64'd10);
        check("ec1_done_data0", bus.rf_data[0], 64'h5);
        check("ec1_done_pc", 64'(bus.pc_after_flush), 64'h104);
        check("ec1_done_stall", 64'(bus.wb_stall), 64'd1);
        check("ec1_done_args7", bus.ecall_args[7], 64'd64);
        bus.ecall_result = '0;
        step();
        check("ec1_after_eflush", 64'(bus.ecall_flush), 64'd0);
        check("ec1_after_stall", 64'(bus.wb_stall), 64'd0);
        check("ec1_after_we", 64'(bus.rf_we), 64'd0);
        check("ec1_pc_hold", 64'(bus.pc_after_flush), 64'h104);
        step();
        check("ec1_flush_pulses", 64'(flush_pulses), 64'd1);

        // ECALL on lane 0 discards lane 1; flush during REQ is ignored; PC+4 wraps
        idle_inputs();
        writes_to_x7 = 0;
        drive_lane(0, 1'b1, 1'b0, 5'd0, 64'h0);
        drive_lane(1, 1'b1, 1'b0, 5'd7, 64'h7777);
        bus.in_is_ecall = 2'b01;
        bus.in_pc[0]    = 32'hFFFF_FFFC;
        model_cycle(exp_we, eseen);
        step();
        check("ec2_we", 64'(bus.rf_we), 64'd0);
        check("ec2_req", 64'(bus.ecall_req), 64'd1);
        idle_inputs();
        drive_lane(0, 1'b1, 1'b0, 5'd8, 64'h8);
        drive_lane(1, 1'b1, 1'b1, 5'd7, 64'h9);
        bus.wb_flush = 1'b1;
        req_cycles = 1;
        for (int c = 0; c < 2; c++) begin
            step();
            if (bus.ecall_req === 1'b1) req_cycles++;
            check("ec2_flush_we", 64'(bus.rf_we), 64'd0);
            check("ec2_flush_eflush", 64'(bus.ecall_flush), 64'd0);
        end
        bus.ecall_ack    = 1'b1;
        bus.ecall_result = 64'h77;
        wait_done(got, req_cycles);
        model_rf[10] = 64'h77;
        check("ec2_req_cycles", 64'(req_cycles), 64'd3);
        check("ec2_done_we", 64'(bus.rf_we), 64'b01);
        check("ec2_done_addr0", 64'(bus.rf_addr[0]), 64'd10);
        check("ec2_done_data0", bus.rf_data[0], 64'h77);
        check("ec2_pc_wrap", 64'(bus.pc_after_flush), 64'h0);
        idle_inputs();
        step();
        check("ec2_x7_writes", 64'(writes_to_x7), 64'd0);

        // Reset while the request is outstanding
        idle_inputs();
        for (int k = 0; k < 8; k++) bus.ecall_reg_val[k] = 64'h2000 + 64'(k);
        drive_lane(0, 1'b1, 1'b0, 5'd0, 64'h0);
        bus.in_is_ecall = 2'b01;
        bus.in_pc[0]    = 32'h200;
        step();
        check("rst_req_before", 64'(bus.ecall_req), 64'd1);
        idle_inputs();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_req", 64'(bus.ecall_req), 64'd0);
        check("rst_async_stall", 64'(bus.wb_stall), 64'd0);
        check("rst_async_we", 64'(bus.rf_we), 64'd0);
        check("rst_async_args7", bus.ecall_args[7], 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_lane(0, 1'b1, 1'b0, 5'd12, 64'h1212);
        model_cycle(exp_we, eseen);
        step();
        check("rst_after_we", 64'(bus.rf_we), 64'b01);
        check("rst_after_data", bus.rf_data[0], 64'h1212);
        check("rst_after_req", 64'(bus.ecall_req), 64'd0);

        // Random retire traffic, no ECALLs, small register range to force collisions
        for (int c = 0; c < 200; c++) begin
            idle_inputs();
            for (int i = 0; i < NL; i++) begin
                d[i] = {$urandom(), $urandom()};
                drive_lane(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           RB'($urandom_range(0, 7)), d[i]);
            end
            bus.wb_flush = ($urandom_range(0, 7) == 0);
            model_cycle(exp_we, eseen);
            step();
            check("rand_we", 64'(bus.rf_we), 64'(exp_we));
            for (int i = 0; i < NL; i++) begin
                if (exp_we[i]) begin
                    check("rand_addr", 64'(bus.rf_addr[i]), 64'(bus.in_rd[i]));
                    check("rand_data", bus.rf_data[i], d[i]);
                end
            end
        end
        idle_inputs();
        step();

        for (int r = 0; r < 32; r++) begin
            check($sformatf("rf_x%0d", r), dut_rf[r], model_rf[r]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
